// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
//   Two-requester front end for the shared 8-bit shift datapath. Requesters A
//   and B are arbitrated round-robin. The granted command (op, amount, data) is
//   latched and executed by a sequential shift engine. The result is returned
//   on a valid/ready response port tagged with the requester id.
//
//   Opcodes: 000 LSR, 001 LSL, 010 ASR, 011 LSL, 100 ROR, 101 ROL.
//   Opcodes 110 and 111 are reserved and return 0.
//
// Ports
//   clk, rst_n                  clock (rising edge), synchronous active-low reset
//   a_valid/a_ready/a_op/a_amt/a_data   requester A command channel
//   b_valid/b_ready/b_op/b_amt/b_data   requester B command channel
//   rsp_valid/rsp_ready         response handshake
//   rsp_id                      0 = result for A, 1 = result for B
//   rsp_data                    shift/rotate result
//   busy                        high whenever the controller is not IDLE
//
// Build option
//   SHIFT_SEQ_ONECYCLE_EN : when defined, the SHIFT state does the whole
//   amt-bit shift in a single barrel step. When undefined (the default), the
//   engine shifts one bit per cycle.
// -----------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int W     = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [2:0]       a_op,
    input  logic [AMT_W-1:0] a_amt,
    input  logic [W-1:0]     a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [2:0]       b_op,
    input  logic [AMT_W-1:0] b_amt,
    input  logic [W-1:0]     b_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [W-1:0]     rsp_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [AMT_W-1:0] cnt_r;
    logic [2:0]       op_r;
    logic [W-1:0]     work_r;
    logic             id_r;
    logic             rr_ptr_r;     // 0: A has priority on a tie, 1: B
    logic             rsp_valid_r;
    logic             busy_r;

    logic             grant_a_s;
    logic             grant_b_s;
    logic [2:0]       sel_op_s;
    logic [AMT_W-1:0] sel_amt_s;
    logic [W-1:0]     sel_data_s;

    function automatic logic is_reserved(input logic [2:0] op);
        return (op[2:1] == 2'b11);
    endfunction

`ifdef SHIFT_SEQ_ONECYCLE_EN
    // Full-amount barrel shift. Rotates use a doubled word so no modulo is needed.
    function automatic logic [W-1:0] shift_n(input logic [2:0] op, input logic [W-1:0] d,
                                              input logic [AMT_W-1:0] n);
        logic [2*W-1:0] dd_v;
        logic [W-1:0]   r_v;
        dd_v = {d, d};
        case (op)
            3'b000:         r_v = d >> n;
            3'b001, 3'b011: r_v = d << n;
            3'b010:         r_v = $unsigned($signed(d) >>> n);
            3'b100: begin
                dd_v = dd_v >> n;
                r_v  = dd_v[W-1:0];
            end
            3'b101: begin
                dd_v = dd_v << n;
                r_v  = dd_v[2*W-1:W];
            end
            default:        r_v = {W{1'b0}};
        endcase
        return r_v;
    endfunction
`else
    // Single-bit step. The ASR step keeps the MSB, so repeated steps fill with the original sign.
    function automatic logic [W-1:0] step1(input logic [2:0] op, input logic [W-1:0] d);
        logic [W-1:0] r_v;
        case (op)
            3'b000:         r_v = {1'b0, d[W-1:1]};
            3'b001, 3'b011: r_v = {d[W-2:0], 1'b0};
            3'b010:         r_v = {d[W-1], d[W-1:1]};
            3'b100:         r_v = {d[0], d[W-1:1]};
            3'b101:         r_v = {d[W-2:0], d[W-1]};
            default:        r_v = {W{1'b0}};
        endcase
        return r_v;
    endfunction
`endif

    // Round-robin grant. A grant is only issued in IDLE, and only one ready is high at a time.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (a_valid && b_valid) begin
                if (rr_ptr_r) begin
                    grant_b_s = 1'b1;
                end else begin
                    grant_a_s = 1'b1;
                end
            end else if (a_valid) begin
                grant_a_s = 1'b1;
            end else if (b_valid) begin
                grant_b_s = 1'b1;
            end else begin
                grant_a_s = 1'b0;
                grant_b_s = 1'b0;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    assign a_ready    = grant_a_s;
    assign b_ready    = grant_b_s;
    assign sel_op_s   = grant_b_s ? b_op   : a_op;
    assign sel_amt_s  = grant_b_s ? b_amt  : a_amt;
    assign sel_data_s = grant_b_s ? b_data : a_data;

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_a_s || grant_b_s) begin
                    // Zero amount and reserved ops need no shifting and go straight to DONE.
                    if ((sel_amt_s == {AMT_W{1'b0}}) || is_reserved(sel_op_s)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
`ifdef SHIFT_SEQ_ONECYCLE_EN
                state_s = ST_DONE;
`else
                if (cnt_r == AMT_W'(1)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_SHIFT;
                end
`endif
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, command latch, shift engine and registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {AMT_W{1'b0}};
            op_r        <= 3'b000;
            work_r      <= {W{1'b0}};
            id_r        <= 1'b0;
            rr_ptr_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            rsp_valid_r <= (state_s == ST_DONE);
            busy_r      <= (state_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (grant_a_s || grant_b_s) begin
                        op_r     <= sel_op_s;
                        cnt_r    <= sel_amt_s;
                        id_r     <= grant_b_s;
                        rr_ptr_r <= ~grant_b_s;
                        work_r   <= is_reserved(sel_op_s) ? {W{1'b0}} : sel_data_s;
                    end
                end
                ST_SHIFT: begin
`ifdef SHIFT_SEQ_ONECYCLE_EN
                    work_r <= shift_n(op_r, work_r, cnt_r);
`else
                    work_r <= step1(op_r, work_r);
                    cnt_r  <= cnt_r - AMT_W'(1);
`endif
                end
                default: begin
                    work_r <= work_r;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = id_r;
    assign rsp_data  = work_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, b_valid, a_ready, b_ready;
    logic [2:0] a_op, b_op, a_amt, b_amt;
    logic [7:0] a_data, b_data;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [7:0] rsp_data;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         lat;
    } exp_t;
    exp_t sb[$];

    typedef struct packed {
        logic       side;
        logic [2:0] op;
        logic [2:0] amt;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.W(8), .AMT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_amt(a_amt), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_amt(b_amt), .b_data(b_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy)
    );

    function automatic logic [7:0] ref_shift(input logic [2:0] op, input logic [2:0] amt,
                                             input logic [7:0] d);
        logic [15:0] ext;
        logic [7:0]  r;
        case (op)
            3'd0: r = d >> amt;
            3'd1, 3'd3: begin ext = {8'h00, d} << amt; r = ext[7:0]; end
            3'd2: begin ext = {{8{d[7]}}, d} >> amt; r = ext[7:0]; end
            3'd4: begin ext = {d, d} >> amt; r = ext[7:0]; end
            3'd5: begin ext = {d, d} << amt; r = ext[15:8]; end
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [2:0] amt);
        if (amt == 3'd0 || op[2:1] == 2'b11) return 1;
`ifdef SHIFT_SEQ_ONECYCLE_EN
        return 2;
`else
        return 1 + int'(amt);
`endif
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; rsp_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Drives one command, waits (bounded) for acceptance, pushes the expected response.
    task automatic issue(input logic side, input logic [2:0] op, input logic [2:0] amt,
                         input logic [7:0] data, input logic [7:0] exp_data);
        exp_t e;
        int   n;
        if (side) begin b_op = op; b_amt = amt; b_data = data; b_valid = 1'b1; end
        else      begin a_op = op; a_amt = amt; a_data = data; a_valid = 1'b1; end
        #1;
        n = 0;
        while (((side ? b_ready : a_ready) !== 1'b1) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        n_cmp++;
        if (n >= 50) begin
            n_err++;
            $display("FAIL issue_accept: ready never seen for side %0d, required within 50 cycles", side);
        end
        e.id = side; e.data = exp_data; e.lat = ref_lat(op, amt);
        sb.push_back(e);
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    // Counts cycles from the one after acceptance until rsp_valid (bounded).
    task automatic wait_rsp(output int lat, output logic id, output logic [7:0] d);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        id = rsp_id; d = rsp_data;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; rsp_ready = 1'b0;
        a_op = 3'd0; a_amt = 3'd0; a_data = 8'h00; b_op = 3'd0; b_amt = 3'd0; b_data = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_id !== 1'b0 || rsp_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset_state: valid=%b busy=%b id=%b data=%h, required 0 0 0 00",
                     rsp_valid, busy, rsp_id, rsp_data);
        end
        n_cmp++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: a_ready=%b b_ready=%b, required 0 0", a_ready, b_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int lat; logic id; logic [7:0] d; exp_t e;
        issue(1'b0, 3'd0, 3'd3, 8'hB4, 8'h16);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_busy: busy=%b, required 1", busy);
        end
        wait_rsp(lat, id, d);
        e = sb.pop_front();
        n_cmp++;
        if (id !== e.id || d !== e.data || lat !== e.lat) begin
            n_err++;
            $display("FAIL single_lsr: id=%0d data=%h lat=%0d, required id=%0d data=%h lat=%0d",
                     id, d, lat, e.id, e.data, e.lat);
        end
        consume();
    endtask

    task automatic test_arbitration();
        int lat; logic id; logic [7:0] d; exp_t e;
        do_reset();
        a_op = 3'd1; a_amt = 3'd3; a_data = 8'hB4;
        b_op = 3'd2; b_amt = 3'd3; b_data = 8'hB4;
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        n_cmp++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_err++;
            $display("FAIL arb_first: a_ready=%b b_ready=%b, required 1 0", a_ready, b_ready);
        end
        e.id = 1'b0; e.data = 8'hA0; e.lat = ref_lat(3'd1, 3'd3); sb.push_back(e);
        @(posedge clk); #1;
        a_valid = 1'b0;
        #1;
        n_cmp++;
        if (b_ready !== 1'b0) begin
            n_err++;
            $display("FAIL arb_busy_ready: b_ready=%b while busy, required 0", b_ready);
        end
        wait_rsp(lat, id, d);
        lat = lat;
        e = sb.pop_front();
        n_cmp++;
        if (id !== e.id || d !== e.data || lat !== e.lat) begin
            n_err++;
            $display("FAIL arb_a_lsl: id=%0d data=%h lat=%0d, required id=%0d data=%h lat=%0d",
                     id, d, lat, e.id, e.data, e.lat);
        end
        consume();
        n_cmp++;
        if (b_ready !== 1'b1) begin
            n_err++;
            $display("FAIL arb_b_next: b_ready=%b in following IDLE, required 1", b_ready);
        end
        e.id = 1'b1; e.data = 8'hF6; e.lat = ref_lat(3'd2, 3'd3); sb.push_back(e);
        @(posedge clk); #1;
        b_valid = 1'b0;
        wait_rsp(lat, id, d);
        e = sb.pop_front();
        n_cmp++;
        if (id !== e.id || d !== e.data || lat !== e.lat) begin
            n_err++;
            $display("FAIL arb_b_asr: id=%0d data=%h lat=%0d, required id=%0d data=%h lat=%0d",
                     id, d, lat, e.id, e.data, e.lat);
        end
        consume();
        // Two more ties: priority must alternate A then B.
        for (int r = 0; r < 2; r++) begin
            a_op = 3'd0; a_amt = 3'd0; a_data = 8'h11;
            b_op = 3'd0; b_amt = 3'd0; b_data = 8'h22;
            a_valid = 1'b1; b_valid = 1'b1;
            #1;
            n_cmp++;
            if (a_ready !== (r == 0) || b_ready !== (r == 1)) begin
                n_err++;
                $display("FAIL arb_alternate round %0d: a_ready=%b b_ready=%b, required %b %b",
                         r, a_ready, b_ready, (r == 0), (r == 1));
            end
            @(posedge clk); #1;
            a_valid = 1'b0; b_valid = 1'b0;
            wait_rsp(lat, id, d);
            n_cmp++;
            if (id !== (r == 1) || d !== ((r == 1) ? 8'h22 : 8'h11) || lat !== 1) begin
                n_err++;
                $display("FAIL arb_alt_rsp round %0d: id=%0d data=%h lat=%0d, required id=%0d lat=1",
                         r, id, d, lat, (r == 1));
            end
            consume();
        end
    endtask

    task automatic test_ops();
        vec_t tbl [0:10];
        int lat; logic id; logic [7:0] d; exp_t e;
        logic [2:0] rop, ramt; logic [7:0] rdat; logic rside;
        tbl[0]  = '{1'b1, 3'd4, 3'd3, 8'hB4, 8'h96};
        tbl[1]  = '{1'b0, 3'd5, 3'd3, 8'hB4, 8'hA5};
        tbl[2]  = '{1'b0, 3'd0, 3'd0, 8'hB4, 8'hB4};
        tbl[3]  = '{1'b1, 3'd2, 3'd0, 8'h5A, 8'h5A};
        tbl[4]  = '{1'b0, 3'd6, 3'd3, 8'hB4, 8'h00};
        tbl[5]  = '{1'b1, 3'd7, 3'd0, 8'hFF, 8'h00};
        tbl[6]  = '{1'b0, 3'd3, 3'd7, 8'hFF, 8'h80};
        tbl[7]  = '{1'b1, 3'd2, 3'd7, 8'h80, 8'hFF};
        tbl[8]  = '{1'b0, 3'd5, 3'd7, 8'h81, 8'hC0};
        tbl[9]  = '{1'b1, 3'd0, 3'd7, 8'h80, 8'h01};
        tbl[10] = '{1'b0, 3'd4, 3'd1, 8'h01, 8'h80};
        for (int i = 0; i < 17; i++) begin
            if (i < 11) begin
                issue(tbl[i].side, tbl[i].op, tbl[i].amt, tbl[i].data, tbl[i].exp);
            end else begin
                rside = 1'($urandom_range(0, 1));
                rop   = 3'($urandom_range(0, 7));
                ramt  = 3'($urandom_range(0, 7));
                rdat  = 8'($urandom_range(0, 255));
                issue(rside, rop, ramt, rdat, ref_shift(rop, ramt, rdat));
            end
            wait_rsp(lat, id, d);
            e = sb.pop_front();
            n_cmp++;
            if (id !== e.id || d !== e.data || lat !== e.lat) begin
                n_err++;
                $display("FAIL ops[%0d]: id=%0d data=%h lat=%0d, required id=%0d data=%h lat=%0d",
                         i, id, d, lat, e.id, e.data, e.lat);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat; logic id; logic [7:0] d; exp_t e; int extra;
        issue(1'b1, 3'd0, 3'd2, 8'hF0, 8'h3C);
        wait_rsp(lat, id, d);
        e = sb.pop_front();
        n_cmp++;
        if (id !== e.id || d !== e.data || lat !== e.lat) begin
            n_err++;
            $display("FAIL bp_rsp: id=%0d data=%h lat=%0d, required id=%0d data=%h lat=%0d",
                     id, d, lat, e.id, e.data, e.lat);
        end
        a_op = 3'd1; a_amt = 3'd1; a_data = 8'h01; b_op = 3'd1; b_amt = 3'd1; b_data = 8'h02;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_id !== e.id
                || a_ready !== 1'b0 || b_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cycle %0d: valid=%b data=%h id=%b ready=%b%b, required 1 %h %b 00",
                         c, rsp_valid, rsp_data, rsp_id, a_ready, b_ready, e.data, e.id);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        consume();
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid !== 1'b0) extra++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (extra != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_single_rsp: extra valid cycles=%0d busy=%b, required 0 0", extra, busy);
        end
    endtask

    task automatic test_reset_mid_shift();
        int lat; logic id; logic [7:0] d; int stale;
        a_op = 3'd0; a_amt = 3'd7; a_data = 8'hFF; a_valid = 1'b1;
        #1;
        @(posedge clk); #1;               // accept edge, now cycle T+1
        a_valid = 1'b0;
        @(posedge clk); #1;               // T+2
        @(posedge clk); #1;               // T+3
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_busy_before: busy=%b, required 1", busy);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_state: valid=%b busy=%b, required 0 0", rsp_valid, busy);
        end
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) stale++;
        end
        n_cmp++;
        if (stale != 0) begin
            n_err++;
            $display("FAIL rst_mid_stale: stale valid cycles=%0d, required 0", stale);
        end
        a_op = 3'd1; a_amt = 3'd0; a_data = 8'h3C; b_op = 3'd1; b_amt = 3'd0; b_data = 8'hC3;
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        n_cmp++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_grant: a_ready=%b b_ready=%b, required 1 0", a_ready, b_ready);
        end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        wait_rsp(lat, id, d);
        n_cmp++;
        if (id !== 1'b0 || d !== 8'h3C || lat !== 1) begin
            n_err++;
            $display("FAIL rst_mid_after: id=%0d data=%h lat=%0d, required 0 3c 1", id, d, lat);
        end
        consume();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_arbitration();
        test_ops();
        test_backpressure();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
